// File: rtl/bram_read_streamer_if.sv
// Command, BRAM-port and output-stream signals of bram_read_streamer.
// master is the streamer side; slave is the side that commands it, serves reads and consumes words.
interface bram_read_streamer_if #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15
) ();

  logic                       start;
  logic [BRAM_ADDR_WIDTH-1:0] base_addr;
  logic [13:0]                num_words;
  logic                       busy;
  logic                       done;

  logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
  logic                       BRAM_EN;
  logic [3:0]                 BRAM_WE;
  logic [31:0]                BRAM_WRDATA;
  logic [31:0]                BRAM_RDDATA;

  logic [31:0]                m_data;
  logic                       m_valid;
  logic                       m_ready;

  modport master (
    input  start, base_addr, num_words, BRAM_RDDATA, m_ready,
    output busy, done, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, m_data, m_valid
  );

  modport slave (
    output start, base_addr, num_words, BRAM_RDDATA, m_ready,
    input  busy, done, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, m_data, m_valid
  );

endinterface

// File: rtl/bram_read_streamer.sv
// Streams a run of 32-bit words from a fixed-latency BRAM read port into a valid/ready stream,
// issuing a read only when the output FIFO is guaranteed room for it when the data returns.
module bram_read_streamer #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic                  BRAM_CLK,
  input logic                  BRAM_RST_N,
  bram_read_streamer_if.master bus
);

  localparam int unsigned WordAw = BRAM_ADDR_WIDTH - 2;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [WordAw-1:0]       base_q, base_d;
  logic [WordAw-1:0]       addr_word;
  logic [13:0]             num_q, num_d;
  logic [13:0]             issued_q, issued_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [CntW-1:0]         outst_q, outst_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [31:0]             mem_q [FIFO_DEPTH];

  logic accept;
  logic issue;
  logic credit_ok;
  logic fifo_wr;
  logic fifo_pop;
  logic fifo_valid;
  logic busy;
  logic done;
  logic unused_base_lsbs;

  assign unused_base_lsbs = ^bus.base_addr[1:0];

  assign accept     = (state_q == StIdle) && bus.start;
  assign fifo_wr    = pipe_q[READ_LATENCY-1];
  assign fifo_valid = (count_q != '0);
  assign fifo_pop   = fifo_valid && bus.m_ready;
  // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, count_q}) < (CntW + 1)'(FIFO_DEPTH);
  assign addr_word  = base_q + WordAw'(issued_q);

  always_ff @(posedge BRAM_CLK or negedge BRAM_RST_N) begin
    if (!BRAM_RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (bus.num_words == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (issued_d == num_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Looking at next-state counts lets done follow the final transfer by one cycle.
        if ((outst_d == '0) && (count_d == '0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      StFetch: begin
        busy  = 1'b1;
        issue = (issued_q < num_q) && credit_ok;
      end
      StDrain: busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    base_d   = base_q;
    num_d    = num_q;
    issued_d = issued_q;
    if (accept) begin
      base_d   = bus.base_addr[BRAM_ADDR_WIDTH-1:2];
      num_d    = bus.num_words;
      issued_d = '0;
    end else if (issue) begin
      issued_d = issued_q + 14'd1;
    end
  end

  always_comb begin
    // One bit per latency stage marks which cycles carry returning read data.
    pipe_d    = pipe_q << 1;
    pipe_d[0] = issue;

    outst_d = outst_q;
    case ({issue, fifo_wr})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: ;
    endcase

    count_d = count_q;
    case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase

    wr_ptr_d = fifo_wr  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
  end

  always_ff @(posedge BRAM_CLK or negedge BRAM_RST_N) begin
    if (!BRAM_RST_N) begin
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      pipe_q   <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      base_q   <= base_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      pipe_q   <= pipe_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge BRAM_CLK or negedge BRAM_RST_N) begin
    if (!BRAM_RST_N) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (fifo_wr) begin
      mem_q[wr_ptr_q] <= bus.BRAM_RDDATA;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.BRAM_EN     = issue;
  assign bus.BRAM_ADDR   = issue ? {addr_word, 2'b00} : '0;
  assign bus.BRAM_WE     = 4'b0000;
  assign bus.BRAM_WRDATA = 32'd0;
  assign bus.m_data      = mem_q[rd_ptr_q];
  assign bus.m_valid     = fifo_valid;

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed bench: three streamers at READ_LATENCY 1, 2 and 3 share one command stream, each
// backed by a BRAM model whose word k holds the value k.
module tb_bram_read_streamer;

  localparam int unsigned AW    = 15;
  localparam int unsigned Depth = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start;
  logic [AW-1:0] base;
  logic [13:0]   num;
  logic [2:0]    rdy;
  logic          clr;
  logic [12:0]   exp_wbase;
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_read_streamer_if #(.BRAM_ADDR_WIDTH(AW)) bus ();

    logic [31:0]   pipe [g+1];
    logic [31:0]   rx_data [64];
    logic [AW-1:0] addr_log [64];
    logic [12:0]   exp_word;
    int            en_cnt, rx_cnt, rx_bad, done_cnt, done_cyc, last_xfer, max_fill;

    assign bus.start       = start;
    assign bus.base_addr   = base;
    assign bus.num_words   = num;
    assign bus.m_ready     = rdy[g];
    assign bus.BRAM_RDDATA = pipe[g];
    assign exp_word        = exp_wbase + rx_cnt[12:0];

    bram_read_streamer #(
      .BRAM_ADDR_WIDTH(AW),
      .READ_LATENCY   (g + 1),
      .FIFO_DEPTH     (Depth)
    ) u_dut (
      .BRAM_CLK  (clk),
      .BRAM_RST_N(rst_n),
      .bus       (bus)
    );

    always @(posedge clk) begin
      if (bus.BRAM_EN) pipe[0] <= {19'b0, bus.BRAM_ADDR[AW-1:2]};
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end

    always @(posedge clk) begin
      if (clr) begin
        en_cnt   <= 0;
        rx_cnt   <= 0;
        rx_bad   <= 0;
        done_cnt <= 0;
      end else begin
        if (bus.BRAM_EN) begin
          if (en_cnt < 64) addr_log[en_cnt[5:0]] <= bus.BRAM_ADDR;
          en_cnt <= en_cnt + 1;
        end
        if (bus.m_valid && bus.m_ready) begin
          if (rx_cnt < 64) rx_data[rx_cnt[5:0]] <= bus.m_data;
          if (bus.m_data !== {19'b0, exp_word}) rx_bad <= rx_bad + 1;
          rx_cnt    <= rx_cnt + 1;
          last_xfer <= cyc;
        end
        if (bus.done) begin
          done_cnt <= done_cnt + 1;
          done_cyc <= cyc;
        end
      end
    end

    always @(negedge clk) begin
      if (clr) max_fill <= 0;
      else if (en_cnt - rx_cnt > max_fill) max_fill <= en_cnt - rx_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [13:0] n);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    base      = b;
    num       = n;
    exp_wbase = b[AW-1:2];
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_all_done(input int budget, input bit rand_rdy, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      if (rand_rdy) rdy = 3'($urandom);
      ok = (g_dut[0].done_cnt != 0) && (g_dut[1].done_cnt != 0) && (g_dut[2].done_cnt != 0);
      n++;
    end
    rdy = 3'b111;
  endtask

  initial begin
    bit ok;
    int n;
    start     = 1'b0;
    base      = '0;
    num       = '0;
    rdy       = 3'b111;
    clr       = 1'b1;
    exp_wbase = '0;
    #1 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_busy",    g_dut[0].bus.busy, 0);
    check("rst_done",    g_dut[0].bus.done, 0);
    check("rst_en",      g_dut[0].bus.BRAM_EN, 0);
    check("rst_addr",    g_dut[0].bus.BRAM_ADDR, 0);
    check("rst_mvalid",  g_dut[0].bus.m_valid, 0);
    check("rst_mdata",   g_dut[0].bus.m_data, 0);
    check("rst_we",      g_dut[0].bus.BRAM_WE, 0);
    check("rst_wrdata",  g_dut[0].bus.BRAM_WRDATA, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch: base 0x10 -> words 4..9
    launch(15'h0010, 14'd6);
    check("basic_busy", g_dut[0].bus.busy, 1);
    wait_all_done(200, 1'b0, ok);
    check("basic_timeout", ok, 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) check("basic_data", g_dut[0].rx_data[k], 32'(4 + k));
    check("basic_rx_cnt",  g_dut[0].rx_cnt, 6);
    check("basic_en_cnt",  g_dut[0].en_cnt, 6);
    check("basic_done_cnt", g_dut[0].done_cnt, 1);
    check("basic_done_lag0", g_dut[0].done_cyc - g_dut[0].last_xfer, 1);
    check("basic_done_lag1", g_dut[1].done_cyc - g_dut[1].last_xfer, 1);
    check("basic_done_lag2", g_dut[2].done_cyc - g_dut[2].last_xfer, 1);
    check("basic_addr0",   g_dut[0].addr_log[0], 15'h0010);
    check("basic_addr5",   g_dut[0].addr_log[5], 15'h0024);
    check("basic_idle",    g_dut[0].bus.busy, 0);

    // Backpressure with a mid-operation start that must be ignored
    rdy = 3'b000;
    launch(15'h0000, 14'd16);
    repeat (9) @(negedge clk);
    base  = 15'h0100;
    num   = 14'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base  = '0;
    num   = '0;
    repeat (9) @(negedge clk);
    check("bp_en_lat1",  g_dut[0].en_cnt, Depth);
    check("bp_en_lat2",  g_dut[1].en_cnt, Depth);
    check("bp_en_lat3",  g_dut[2].en_cnt, Depth);
    check("bp_fill",     g_dut[0].max_fill, Depth);
    check("bp_mvalid",   g_dut[0].bus.m_valid, 1);
    check("bp_mdata",    g_dut[0].bus.m_data, 0);
    check("bp_busy",     g_dut[0].bus.busy, 1);
    rdy = 3'b111;
    wait_all_done(300, 1'b0, ok);
    check("bp_timeout", ok, 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) check("bp_data", g_dut[0].rx_data[k], 32'(k));
    check("bp_rx_lat1",  g_dut[0].rx_cnt, 16);
    check("bp_rx_lat3",  g_dut[2].rx_cnt, 16);
    check("bp_bad_lat3", g_dut[2].rx_bad, 0);
    check("bp_en_total", g_dut[0].en_cnt, 16);
    check("bp_done_cnt", g_dut[0].done_cnt, 1);

    // Address wrap; base LSBs are ignored
    launch(15'h7FFB, 14'd4);
    wait_all_done(200, 1'b0, ok);
    check("wrap_timeout", ok, 1);
    repeat (3) @(negedge clk);
    check("wrap_addr0", g_dut[0].addr_log[0], 15'h7FF8);
    check("wrap_addr1", g_dut[0].addr_log[1], 15'h7FFC);
    check("wrap_addr2", g_dut[0].addr_log[2], 15'h0000);
    check("wrap_addr3", g_dut[0].addr_log[3], 15'h0004);
    check("wrap_addr3_lat2", g_dut[1].addr_log[3], 15'h0004);
    check("wrap_addr3_lat3", g_dut[2].addr_log[3], 15'h0004);
    check("wrap_data0", g_dut[0].rx_data[0], 32'h1FFE);
    check("wrap_data1", g_dut[0].rx_data[1], 32'h1FFF);
    check("wrap_data2", g_dut[0].rx_data[2], 32'h0000);
    check("wrap_data3", g_dut[0].rx_data[3], 32'h0001);

    // Zero length
    launch(15'h0123, 14'd0);
    check("zero_done",   g_dut[0].bus.done, 1);
    check("zero_mvalid", g_dut[0].bus.m_valid, 0);
    repeat (2) @(negedge clk);
    check("zero_done_cnt", g_dut[0].done_cnt, 1);
    check("zero_en_cnt",   g_dut[0].en_cnt, 0);
    check("zero_rx_cnt",   g_dut[0].rx_cnt, 0);

    // Reset mid-run, then a fresh two-word run
    launch(15'h0000, 14'd10);
    n = 0;
    while (g_dut[0].rx_cnt < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rmid_reach3", 32'(g_dut[0].rx_cnt >= 3), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_busy",   g_dut[0].bus.busy, 0);
    check("rmid_done",   g_dut[0].bus.done, 0);
    check("rmid_en",     g_dut[0].bus.BRAM_EN, 0);
    check("rmid_addr",   g_dut[0].bus.BRAM_ADDR, 0);
    check("rmid_mvalid", g_dut[0].bus.m_valid, 0);
    check("rmid_mvalid_lat3", g_dut[2].bus.m_valid, 0);
    repeat (3) @(negedge clk);
    check("rmid_no_done", g_dut[0].done_cnt, 0);
    rst_n = 1'b1;
    launch(15'h0040, 14'd2);
    wait_all_done(100, 1'b0, ok);
    check("rmid_timeout", ok, 1);
    repeat (3) @(negedge clk);
    check("rmid_rx_cnt",   g_dut[0].rx_cnt, 2);
    check("rmid_data0",    g_dut[0].rx_data[0], 32'h10);
    check("rmid_data1",    g_dut[0].rx_data[1], 32'h11);
    check("rmid_done_cnt", g_dut[0].done_cnt, 1);
    check("rmid_rx_lat3",  g_dut[2].rx_cnt, 2);

    // Latency sweep under random m_ready
    rdy = 3'($urandom);
    launch(15'h0200, 14'd20);
    wait_all_done(2000, 1'b1, ok);
    check("sweep_timeout", ok, 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check("sweep_lat1", g_dut[0].rx_data[k], 32'(8'h80 + k));
      check("sweep_lat2", g_dut[1].rx_data[k], 32'(8'h80 + k));
      check("sweep_lat3", g_dut[2].rx_data[k], 32'(8'h80 + k));
    end
    check("sweep_fill1", 32'(g_dut[0].max_fill <= Depth), 1);
    check("sweep_fill2", 32'(g_dut[1].max_fill <= Depth), 1);
    check("sweep_fill3", 32'(g_dut[2].max_fill <= Depth), 1);
    check("sweep_rx3",   g_dut[2].rx_cnt, 20);
    check("sweep_en3",   g_dut[2].en_cnt, 20);

    // Full 32 KB sweep from base 0
    launch(15'h0000, 14'd8192);
    wait_all_done(30000, 1'b0, ok);
    check("full_timeout", ok, 1);
    repeat (3) @(negedge clk);
    check("full_rx1",   g_dut[0].rx_cnt, 8192);
    check("full_rx3",   g_dut[2].rx_cnt, 8192);
    check("full_bad1",  g_dut[0].rx_bad, 0);
    check("full_bad2",  g_dut[1].rx_bad, 0);
    check("full_bad3",  g_dut[2].rx_bad, 0);
    check("full_en1",   g_dut[0].en_cnt, 8192);
    check("full_done1", g_dut[0].done_cnt, 1);
    check("full_d63",   g_dut[0].rx_data[63], 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
